// File: rtl/video_timer.sv
// Video raster timer: pixel/line counters, blanking and sync decode,
// a programmable line interrupt and a light-pen position latch.
module video_timer #(
  parameter int HTOTAL      = 384,
  parameter int HSYNC_START = 288,
  parameter int HSYNC_LEN   = 28
) (
  input  logic       MasterClock,
  input  logic       RESETL,
  input  logic       PCE,
  input  logic       NTSC,
  input  logic       LP,
  input  logic       WR,
  input  logic [1:0] ADDR,
  input  logic [7:0] DIN,
  output logic [8:0] HCNT,
  output logic [8:0] VCNT,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       HSYNCL,
  output logic       VSYNCL,
  output logic       CSYNCL,
  output logic       LINTL,
  output logic [8:0] LPH,
  output logic [8:0] LPV
);

  typedef enum logic [1:0] {
    REG_INT_LO  = 2'd0,
    REG_INT_HI  = 2'd1,
    REG_INT_ACK = 2'd2,
    REG_NONE    = 2'd3
  } reg_addr_e;

  localparam logic [8:0] H_LAST       = 9'(HTOTAL - 1);
  localparam logic [8:0] HS_BEG       = 9'(HSYNC_START);
  localparam logic [8:0] HS_END       = 9'(HSYNC_START + HSYNC_LEN);
  localparam logic [8:0] HBLANK_START = 9'd256;
  localparam logic [8:0] VBLANK_START = 9'd200;
  localparam logic [8:0] V_LAST_NTSC  = 9'd261;
  localparam logic [8:0] V_LAST_PAL   = 9'd311;

  logic [8:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic       std_q, std_d, std_valid_q, std_valid_d;
  logic       hblank_q, hblank_d, vblank_q, vblank_d;
  logic       hsyncl_q, hsyncl_d, vsyncl_q, vsyncl_d, csyncl_q, csyncl_d;
  logic [8:0] intline_q, intline_d;
  logic       lintl_q, lintl_d;
  logic       lp_s1_q, lp_s1_d, lp_s2_q, lp_s2_d, lp_s3_q, lp_s3_d;
  logic       lp_lock_q, lp_lock_d;
  logic [8:0] lph_q, lph_d, lpv_q, lpv_d;

  logic       std_eff, line_step, frame_wrap, int_ack, int_set, lp_capture;
  logic [8:0] v_last;

  // The standard register is empty until the first clock after reset, so the
  // live NTSC input stands in for it while RESETL is held low.
  assign std_eff = std_valid_q ? std_q : NTSC;
  assign v_last  = std_eff ? V_LAST_NTSC : V_LAST_PAL;

  // Next counter values and the frame-standard register; all gated by PCE.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    line_step   = 1'b0;
    frame_wrap  = 1'b0;
    std_valid_d = 1'b1;
    std_d       = std_valid_q ? std_q : NTSC;
    if (PCE) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d    = '0;
        line_step = 1'b1;
        if (vcnt_q == v_last) begin
          vcnt_d     = '0;
          frame_wrap = 1'b1;
          std_d      = NTSC;
        end else begin
          vcnt_d = vcnt_q + 9'd1;
        end
      end else begin
        hcnt_d = hcnt_q + 9'd1;
      end
    end
  end

  // Blank/sync decode from the next counter values so the registered flags
  // line up with the counters they describe.
  always_comb begin
    hblank_d = (hcnt_d >= HBLANK_START);
    vblank_d = (vcnt_d >= VBLANK_START);
    hsyncl_d = !((hcnt_d >= HS_BEG) && (hcnt_d < HS_END));
    if (std_d) vsyncl_d = !((vcnt_d >= 9'd220) && (vcnt_d <= 9'd222));
    else       vsyncl_d = !((vcnt_d >= 9'd250) && (vcnt_d <= 9'd252));
    csyncl_d = hsyncl_d & vsyncl_d;
  end

  // Register writes and the line interrupt; a set beats a same-cycle ack.
  always_comb begin
    intline_d = intline_q;
    int_ack   = 1'b0;
    if (WR) begin
      case (reg_addr_e'(ADDR))
        REG_INT_LO:  intline_d[7:0] = DIN;
        REG_INT_HI:  intline_d[8]   = DIN[0];
        REG_INT_ACK: int_ack        = 1'b1;
        default:     ;
      endcase
    end
    int_set = line_step && (vcnt_d == intline_q);
    if (int_set)      lintl_d = 1'b0;
    else if (int_ack) lintl_d = 1'b1;
    else              lintl_d = lintl_q;
  end

  // Light-pen synchroniser, falling-edge detect and once-per-frame latch.
  always_comb begin
    lp_s1_d    = LP;
    lp_s2_d    = lp_s1_q;
    lp_s3_d    = lp_s2_q;
    lp_capture = lp_s3_q && !lp_s2_q && !lp_lock_q;
    lph_d      = lp_capture ? hcnt_q : lph_q;
    lpv_d      = lp_capture ? vcnt_q : lpv_q;
    if (frame_wrap)      lp_lock_d = 1'b0;
    else if (lp_capture) lp_lock_d = 1'b1;
    else                 lp_lock_d = lp_lock_q;
  end

  // State register; reset values make every output idle and INTLINE unmatchable.
  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      std_q       <= 1'b0;
      std_valid_q <= 1'b0;
      hblank_q    <= 1'b0;
      vblank_q    <= 1'b0;
      hsyncl_q    <= 1'b1;
      vsyncl_q    <= 1'b1;
      csyncl_q    <= 1'b1;
      intline_q   <= 9'h1FF;
      lintl_q     <= 1'b1;
      lp_s1_q     <= 1'b1;
      lp_s2_q     <= 1'b1;
      lp_s3_q     <= 1'b1;
      lp_lock_q   <= 1'b0;
      lph_q       <= '0;
      lpv_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      std_q       <= std_d;
      std_valid_q <= std_valid_d;
      hblank_q    <= hblank_d;
      vblank_q    <= vblank_d;
      hsyncl_q    <= hsyncl_d;
      vsyncl_q    <= vsyncl_d;
      csyncl_q    <= csyncl_d;
      intline_q   <= intline_d;
      lintl_q     <= lintl_d;
      lp_s1_q     <= lp_s1_d;
      lp_s2_q     <= lp_s2_d;
      lp_s3_q     <= lp_s3_d;
      lp_lock_q   <= lp_lock_d;
      lph_q       <= lph_d;
      lpv_q       <= lpv_d;
    end
  end

  assign HCNT   = hcnt_q;
  assign VCNT   = vcnt_q;
  assign HBLANK = hblank_q;
  assign VBLANK = vblank_q;
  assign HSYNCL = hsyncl_q;
  assign VSYNCL = vsyncl_q;
  assign CSYNCL = csyncl_q;
  assign LINTL  = lintl_q;
  assign LPH    = lph_q;
  assign LPV    = lpv_q;

endmodule

// File: tb/tb_video_timer.sv
// Directed bench for video_timer. dut_h uses the default line length for the
// horizontal decode; dut_v uses an 8-pixel line so whole frames stay short.
module tb_video_timer;

  logic       clk = 1'b0;
  logic       rstl, pce, ntsc, lp, wr;
  logic [1:0] addr;
  logic [7:0] din;

  logic [8:0] h_hcnt, h_vcnt, h_lph, h_lpv;
  logic       h_hblank, h_vblank, h_hsyncl, h_vsyncl, h_csyncl, h_lintl;
  logic [8:0] v_hcnt, v_vcnt, v_lph, v_lpv;
  logic       v_hblank, v_vblank, v_hsyncl, v_vsyncl, v_csyncl, v_lintl;

  int checks = 0;
  int errors = 0;
  int m_h, m_v, hh;
  bit m_std;

  localparam logic [45:0] RST_VEC = {9'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 9'd0, 9'd0};

  always #5 clk = ~clk;

  video_timer dut_h (
    .MasterClock(clk), .RESETL(rstl), .PCE(pce), .NTSC(ntsc), .LP(lp), .WR(wr),
    .ADDR(addr), .DIN(din), .HCNT(h_hcnt), .VCNT(h_vcnt), .HBLANK(h_hblank),
    .VBLANK(h_vblank), .HSYNCL(h_hsyncl), .VSYNCL(h_vsyncl), .CSYNCL(h_csyncl),
    .LINTL(h_lintl), .LPH(h_lph), .LPV(h_lpv)
  );

  video_timer #(.HTOTAL(8), .HSYNC_START(2), .HSYNC_LEN(3)) dut_v (
    .MasterClock(clk), .RESETL(rstl), .PCE(pce), .NTSC(ntsc), .LP(lp), .WR(wr),
    .ADDR(addr), .DIN(din), .HCNT(v_hcnt), .VCNT(v_vcnt), .HBLANK(v_hblank),
    .VBLANK(v_vblank), .HSYNCL(v_hsyncl), .VSYNCL(v_vsyncl), .CSYNCL(v_csyncl),
    .LINTL(v_lintl), .LPH(v_lph), .LPV(v_lpv)
  );

  function automatic logic [45:0] pack_h();
    return {h_hcnt, h_vcnt, h_hblank, h_vblank, h_hsyncl, h_vsyncl, h_csyncl, h_lintl, h_lph, h_lpv};
  endfunction

  function automatic logic [45:0] pack_v();
    return {v_hcnt, v_vcnt, v_hblank, v_vblank, v_hsyncl, v_vsyncl, v_csyncl, v_lintl, v_lph, v_lpv};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Position model for the 8-pixel instance plus a pixel count for dut_h.
  task automatic model_adv();
    hh = (hh == 383) ? 0 : hh + 1;
    if (m_h == 7) begin
      m_h = 0;
      if (m_v == (m_std ? 261 : 311)) begin
        m_v   = 0;
        m_std = ntsc;
      end else begin
        m_v++;
      end
    end else begin
      m_h++;
    end
  endtask

  // One pixel: PCE high for one clock, then low for two.
  task automatic step();
    pce = 1'b1;
    tick();
    pce = 1'b0;
    model_adv();
    tick();
    tick();
  endtask

  task automatic advance_to(input int v, input int h);
    for (int i = 0; i < 5000 && !(m_v == v && m_h == h); i++) step();
  endtask

  task automatic do_reset(input bit n);
    ntsc = n;
    rstl = 1'b0;
    repeat (3) tick();
    rstl  = 1'b1;
    m_h   = 0;
    m_v   = 0;
    hh    = 0;
    m_std = n;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    addr = a;
    din  = d;
    wr   = 1'b1;
    tick();
    wr = 1'b0;
    tick();
  endtask

  task automatic lp_pulse();
    lp = 1'b0;
    repeat (4) tick();
    lp = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rstl = 1'b0;
    repeat (3) tick();
    checks++; if (pack_h() !== RST_VEC) begin errors++; $display("FAIL reset_h: got %h want %h", pack_h(), RST_VEC); end
    checks++; if (pack_v() !== RST_VEC) begin errors++; $display("FAIL reset_v: got %h want %h", pack_v(), RST_VEC); end
    do_reset(1'b0);
    step();
    checks++; if (v_hcnt !== 9'd1 || v_vcnt !== 9'd0) begin errors++; $display("FAIL first_pce: got %0d/%0d want 1/0", v_hcnt, v_vcnt); end
  endtask

  task automatic test_horizontal();
    do_reset(1'b0);
    repeat (255) step();
    checks++; if (h_hcnt !== 9'd255 || h_hblank !== 1'b0) begin errors++; $display("FAIL hblank_255: got %0d/%b want 255/0", h_hcnt, h_hblank); end
    step();
    checks++; if (h_hcnt !== 9'd256 || h_hblank !== 1'b1) begin errors++; $display("FAIL hblank_256: got %0d/%b want 256/1", h_hcnt, h_hblank); end
    repeat (31) step();
    checks++; if (h_hcnt !== 9'd287 || h_hsyncl !== 1'b1) begin errors++; $display("FAIL hsync_287: got %0d/%b want 287/1", h_hcnt, h_hsyncl); end
    step();
    checks++; if (h_hsyncl !== 1'b0 || h_csyncl !== 1'b0) begin errors++; $display("FAIL hsync_288: got hs %b cs %b want 0 0", h_hsyncl, h_csyncl); end
    repeat (27) step();
    checks++; if (h_hcnt !== 9'd315 || h_hsyncl !== 1'b0) begin errors++; $display("FAIL hsync_315: got %0d/%b want 315/0", h_hcnt, h_hsyncl); end
    step();
    checks++; if (h_hcnt !== 9'd316 || h_hsyncl !== 1'b1) begin errors++; $display("FAIL hsync_316: got %0d/%b want 316/1", h_hcnt, h_hsyncl); end
    repeat (67) step();
    checks++; if (h_hcnt !== 9'd383 || h_vcnt !== 9'd0) begin errors++; $display("FAIL hcnt_383: got %0d/%0d want 383/0", h_hcnt, h_vcnt); end
    step();
    checks++; if (h_hcnt !== 9'd0 || h_vcnt !== 9'd1 || h_hblank !== 1'b0) begin errors++; $display("FAIL hwrap: got %0d/%0d/%b want 0/1/0", h_hcnt, h_vcnt, h_hblank); end
    repeat (6) tick();
    checks++; if (h_hcnt !== 9'd0 || h_vcnt !== 9'd1) begin errors++; $display("FAIL pce_idle: got %0d/%0d want 0/1", h_hcnt, h_vcnt); end
  endtask

  task automatic test_pal_frame();
    int wraps = 0;
    int vs_low = 0;
    logic [8:0] prev;
    logic exp_vs;
    do_reset(1'b0);
    for (int i = 0; i < 312 * 8; i++) begin
      prev = v_vcnt;
      step();
      exp_vs = !(m_v >= 250 && m_v <= 252);
      checks++;
      if ({v_hcnt, v_vcnt, v_vsyncl} !== {9'(m_h), 9'(m_v), exp_vs}) begin
        errors++;
        $display("FAIL pal_pos: got %0d/%0d vs %b want %0d/%0d vs %b", v_hcnt, v_vcnt, v_vsyncl, m_h, m_v, exp_vs);
      end
      if (prev == 9'd311 && v_vcnt == 9'd0) wraps++;
      if (v_vsyncl == 1'b0) vs_low++;
    end
    checks++; if (wraps !== 1) begin errors++; $display("FAIL pal_wraps: got %0d want 1", wraps); end
    checks++; if (vs_low !== 24) begin errors++; $display("FAIL pal_vsync_len: got %0d want 24", vs_low); end
  endtask

  task automatic test_ntsc_switch();
    do_reset(1'b0);
    advance_to(100, 0);
    checks++; if (v_vcnt !== 9'd100) begin errors++; $display("FAIL ntsc_at100: got %0d want 100", v_vcnt); end
    ntsc = 1'b1;
    advance_to(250, 0);
    checks++; if (v_vsyncl !== 1'b0) begin errors++; $display("FAIL ntsc_pal_vsync: got %b want 0", v_vsyncl); end
    advance_to(311, 7);
    checks++; if (v_vcnt !== 9'd311) begin errors++; $display("FAIL ntsc_reach311: got %0d want 311", v_vcnt); end
    step();
    checks++; if (v_vcnt !== 9'd0) begin errors++; $display("FAIL ntsc_wrap311: got %0d want 0", v_vcnt); end
    advance_to(220, 0);
    checks++; if (v_vsyncl !== 1'b0) begin errors++; $display("FAIL ntsc_vsync220: got %b want 0", v_vsyncl); end
    advance_to(261, 7);
    step();
    checks++; if (v_vcnt !== 9'd0) begin errors++; $display("FAIL ntsc_wrap261: got %0d want 0", v_vcnt); end
    ntsc = 1'b0;
  endtask

  task automatic test_interrupt();
    do_reset(1'b0);
    wr_reg(2'd0, 8'h32);
    wr_reg(2'd1, 8'h00);
    advance_to(49, 7);
    checks++; if (v_lintl !== 1'b1) begin errors++; $display("FAIL int_before: got %b want 1", v_lintl); end
    step();
    checks++; if (v_vcnt !== 9'd50 || v_lintl !== 1'b0) begin errors++; $display("FAIL int_set50: got %0d/%b want 50/0", v_vcnt, v_lintl); end
    advance_to(60, 0);
    checks++; if (v_lintl !== 1'b0) begin errors++; $display("FAIL int_held: got %b want 0", v_lintl); end
    wr_reg(2'd2, 8'hA5);
    checks++; if (v_lintl !== 1'b1) begin errors++; $display("FAIL int_ack: got %b want 1", v_lintl); end
    wr_reg(2'd0, 8'h3D);
    advance_to(60, 7);
    pce  = 1'b1;
    wr   = 1'b1;
    addr = 2'd2;
    tick();
    pce = 1'b0;
    wr  = 1'b0;
    model_adv();
    tick();
    checks++; if (v_vcnt !== 9'd61 || v_lintl !== 1'b0) begin errors++; $display("FAIL int_set_wins: got %0d/%b want 61/0", v_vcnt, v_lintl); end
    wr_reg(2'd3, 8'hFF);
    checks++; if (v_lintl !== 1'b0) begin errors++; $display("FAIL int_addr3: got %b want 0", v_lintl); end
    wr_reg(2'd2, 8'h00);
    checks++; if (v_lintl !== 1'b1) begin errors++; $display("FAIL int_ack2: got %b want 1", v_lintl); end
  endtask

  task automatic test_lightpen();
    do_reset(1'b0);
    advance_to(40, 4);
    lp_pulse();
    checks++; if (v_lph !== 9'd4 || v_lpv !== 9'd40) begin errors++; $display("FAIL lp_first: got %0d/%0d want 4/40", v_lph, v_lpv); end
    checks++; if (h_lph !== 9'd324 || h_lpv !== 9'd0) begin errors++; $display("FAIL lp_first_h: got %0d/%0d want 324/0", h_lph, h_lpv); end
    advance_to(80, 1);
    lp_pulse();
    checks++; if (v_lph !== 9'd4 || v_lpv !== 9'd40) begin errors++; $display("FAIL lp_locked: got %0d/%0d want 4/40", v_lph, v_lpv); end
    advance_to(5, 3);
    lp_pulse();
    checks++; if (v_lph !== 9'd3 || v_lpv !== 9'd5) begin errors++; $display("FAIL lp_next_frame: got %0d/%0d want 3/5", v_lph, v_lpv); end
  endtask

  task automatic test_reset_midframe();
    do_reset(1'b0);
    wr_reg(2'd0, 8'h32);
    wr_reg(2'd1, 8'h00);
    advance_to(20, 2);
    lp_pulse();
    advance_to(150, 3);
    checks++; if (v_lintl !== 1'b0 || v_vcnt !== 9'd150) begin errors++; $display("FAIL mid_pre: got %b/%0d want 0/150", v_lintl, v_vcnt); end
    @(posedge clk);
    #3;
    rstl = 1'b0;
    #1;
    checks++; if (pack_v() !== RST_VEC) begin errors++; $display("FAIL mid_reset_v: got %h want %h", pack_v(), RST_VEC); end
    checks++; if (pack_h() !== RST_VEC) begin errors++; $display("FAIL mid_reset_h: got %h want %h", pack_h(), RST_VEC); end
    repeat (3) tick();
    rstl  = 1'b1;
    m_h   = 0;
    m_v   = 0;
    hh    = 0;
    m_std = 1'b0;
    tick();
    step();
    checks++; if (v_hcnt !== 9'd1 || v_vcnt !== 9'd0) begin errors++; $display("FAIL mid_resume: got %0d/%0d want 1/0", v_hcnt, v_vcnt); end
    advance_to(51, 0);
    checks++; if (v_lintl !== 1'b1) begin errors++; $display("FAIL mid_intline: got %b want 1", v_lintl); end
  endtask

  initial begin
    rstl = 1'b0;
    pce  = 1'b0;
    ntsc = 1'b0;
    lp   = 1'b1;
    wr   = 1'b0;
    addr = 2'd0;
    din  = 8'd0;
    m_h  = 0;
    m_v  = 0;
    hh   = 0;
    m_std = 1'b0;
    test_reset();
    test_horizontal();
    test_pal_frame();
    test_ntsc_switch();
    test_interrupt();
    test_lightpen();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timer.md
VIDEO_TIMER -- requirements
Module: video_timer

Interface
REQ-001 Parameter HTOTAL, default 384: pixel clocks per line.
REQ-002 Parameter HSYNC_START, default 288: HCNT value at which HSYNCL asserts.
REQ-003 Parameter HSYNC_LEN, default 28: HSYNCL low width, in pixel clocks.
REQ-004 MasterClock  in  1  sole clock; all state changes on its rising edge.
REQ-005 RESETL  in  1  reset, asynchronous, active-low.
REQ-006 PCE  in  1  pixel clock enable: one MasterClock-wide pulse per CCLK period.
REQ-007 NTSC  in  1  frame standard select: 1 = 262 lines, 0 = 312 lines (PAL).
REQ-008 LP  in  1  light-pen strobe, asynchronous, active-low.
REQ-009 WR  in  1  register write strobe, one MasterClock cycle wide.
REQ-010 ADDR  in  2  register select.
REQ-011 DIN  in  8  write data.
REQ-012 HCNT  out  9  horizontal pixel counter.
REQ-013 VCNT  out  9  line counter.
REQ-014 HBLANK, VBLANK  out  1 each  blanking flags, active-high.
REQ-015 HSYNCL, VSYNCL, CSYNCL  out  1 each  syncs, active-low.
REQ-016 LINTL  out  1  line interrupt, active-low, level-held.
REQ-017 LPH, LPV  out  9 each  light-pen latched HCNT and VCNT.

Function
REQ-018 HCNT SHALL increment only on cycles where PCE=1, and SHALL wrap from HTOTAL-1 to 0.
REQ-019 VCNT SHALL increment on the PCE cycle in which HCNT wraps, and SHALL wrap from VMAX to 0, where VMAX = 261 (NTSC) or 311 (PAL).
REQ-020 NTSC SHALL be sampled into an internal standard register only on the VCNT wrap to 0; mid-frame changes SHALL have no effect until the next frame.
REQ-021 Registered outputs SHALL update in the same cycle as the counters: HBLANK = (HCNT >= 256); VBLANK = (VCNT >= 200).
REQ-022 HSYNCL SHALL be 0 for HSYNC_START <= HCNT < HSYNC_START+HSYNC_LEN.
REQ-023 VSYNCL SHALL be 0 for VCNT 250..252 (PAL) or VCNT 220..222 (NTSC).
REQ-024 CSYNCL SHALL equal HSYNCL AND VSYNCL.
REQ-025 Register writes take effect in the cycle after WR=1:
- ADDR=0: DIN[7:0] -> INTLINE[7:0].
- ADDR=1: DIN[0] -> INTLINE[8].
- ADDR=2: interrupt acknowledge; data ignored.
- ADDR=3: no effect.
REQ-026 LINTL SHALL go to 0 on the cycle VCNT takes a new value equal to INTLINE, and SHALL stay 0 until acknowledged.
REQ-027 If an interrupt set and an acknowledge occur in the same cycle, set SHALL win and LINTL SHALL stay 0.
REQ-028 LP SHALL pass through a 2-flop synchroniser. On a detected falling edge, LPH and LPV SHALL capture the current HCNT and VCNT.
REQ-029 Only the first LP capture per frame SHALL be accepted; a lock flag blocks further captures and clears on the VCNT wrap to 0.
REQ-030 When PCE=0, no counter, sync, blank or interrupt state SHALL change. Register writes and LP synchronisation SHALL proceed regardless of PCE.

Reset
REQ-031 While RESETL=0, the following SHALL hold regardless of the clock:
- HCNT=0, VCNT=0
- HBLANK=0, VBLANK=0
- HSYNCL=1, VSYNCL=1, CSYNCL=1, LINTL=1
- LPH=0, LPV=0
- INTLINE=0x1FF (never matches a valid line)
- LP lock clear, LP synchroniser =1
- standard register = NTSC input value
REQ-032 Deassertion mid-line SHALL restart counting from HCNT=0, VCNT=0 on the first PCE after release.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no output glitch beyond the values in REQ-031.

Verification
REQ-034 PCE every 3rd cycle, PAL, 384*312 PCE pulses -> HCNT wraps 383->0 each line; VCNT wraps 311->0 once; VSYNCL low for exactly 3 lines.
REQ-035 HCNT 287->288 -> HSYNCL 0; HCNT 315->316 -> HSYNCL 1; HBLANK rises at HCNT=256.
REQ-036 NTSC 0->1 at VCNT=100 -> VCNT still reaches 311; the following frame wraps at 261.
REQ-037 Write INTLINE=0x032 (ADDR0=0x32, ADDR1=0x00) -> LINTL 0 when VCNT becomes 50; ack at VCNT=60 -> LINTL 1; ack coincident with set -> LINTL stays 0.
REQ-038 Two LP pulses at (HCNT 100, VCNT 40) and (HCNT 10, VCNT 80) -> LPH=100, LPV=40 (±2-cycle sync latency, no PCE advance); new capture accepted after frame wrap.
REQ-039 RESETL pulsed low at VCNT=150 with LINTL=0 -> all outputs at REQ-031 values immediately; counting resumes from 0.
